alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid[1:0]  input  2  per-port request valid (index = port).
REQ-005 req_ready[1:0]  output  2  per-port request accept.
REQ-006 req_a0, req_b0, req_a1, req_b1  input  WIDTH each  operands for port 0 / port 1.
REQ-007 req_op0, req_op1  input  3 each  ALUControl code for port 0 / port 1.
REQ-008 rsp_valid[1:0]  output  2  per-port result valid.
REQ-009 rsp_ready[1:0]  input  2  per-port result accept.
REQ-010 rsp_result  output  WIDTH  result for the port whose rsp_valid is high.
REQ-011 alu_srca, alu_srcb  output  WIDTH each  to the shared ALU SrcA/SrcB.
REQ-012 alu_control  output  3  to the shared ALU ALUControl.
REQ-013 alu_result  input  WIDTH  from the shared ALU ALUResult (combinational).
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, EXEC, RESP; exactly one transaction outstanding.
REQ-016 IDLE: req_ready[g] high for granted port g only, and only if req_valid[g]; otherwise both low. EXEC/RESP: req_ready = 2'b00.
REQ-017 Grant: one port valid -> that port; both valid -> port != last_grant (round-robin).
REQ-018 last_grant updates to g on each accept; resets to 1 so port 0 wins first contention.
REQ-019 Accept (req_valid[g] & req_ready[g]) in cycle N: operands/op of port g latched into alu_srca/alu_srcb/alu_control, owner <= g, state -> EXEC at N+1.
REQ-020 EXEC (cycle N+1): alu_result captured into result register at end of cycle; state -> RESP.
REQ-021 RESP (from N+2): rsp_valid[owner] = 1, other bit 0; rsp_result = captured result, stable until handshake.
REQ-022 rsp_valid[owner] & rsp_ready[owner] -> IDLE next cycle; no new accept in the handshake cycle (min 3 cycles/op).
REQ-023 rsp_ready asserted early (before RESP) has no effect; rsp_ready of non-owner port ignored.
REQ-024 alu_srca/alu_srcb/alu_control registered; hold last accepted values outside EXEC.
REQ-025 Opcode not checked; codes 100/110/111 forwarded; result is whatever alu_result returns (SrcA).
REQ-026 req_ready combinationally depends on req_valid; requesters SHALL NOT make req_valid depend on req_ready and SHALL hold payload until accepted.
REQ-027 No combinational path from alu_result to any output.

Reset
REQ-028 reset_n low: state IDLE, req_ready 0, rsp_valid 0, rsp_result 0, alu_srca/srcb 0, alu_control 000, busy 0, last_grant 1, owner 0.
REQ-029 Reset asserted mid-transaction (EXEC or RESP) discards it; no rsp_valid after release until a new accept.
REQ-030 First accept possible in first rising edge after reset_n deasserts.

Verification
REQ-031 Port 0 only, a=5, b=7, op=000, rsp_ready=1 -> accept cycle N, rsp_valid=2'b01 at N+2, rsp_result=12, IDLE at N+3.
REQ-032 Both ports valid every cycle (p0: 9-4 op 001; p1: 3|12 op 011), rsp_ready=11 -> grants 0,1,0,1; results 5,15 alternate; 3 cycles apart.
REQ-033 Port 1, a=2, b=3, op=101, rsp_ready=0 for 10 cycles -> rsp_valid=2'b10, rsp_result=1 held stable, req_ready=00, busy=1 throughout; completes on rsp_ready[1]=1.
REQ-034 Port 0, a=0xFFFFFFFF, b=1, op=000 -> rsp_result=0 (wrap); op=110 -> rsp_result=0xFFFFFFFF (default path).
REQ-035 reset_n low during EXEC of a port 0 request -> all outputs at reset values; after release, no rsp_valid without new request; next contention grants port 0.
REQ-036 rsp_ready[1]=1 while port 0 owns RESP -> no handshake; state stays RESP until rsp_ready[0]=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for one shared combinational ALU.
// One transaction is in flight at a time: a request is accepted in IDLE, its
// operands drive the ALU for one EXEC cycle, and the captured result is then
// held in RESP until the owning port takes it.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             last_grant_reg;
    logic             owner_reg;
    logic [WIDTH-1:0] srca_reg;
    logic [WIDTH-1:0] srcb_reg;
    logic [2:0]       control_reg;
    logic [WIDTH-1:0] result_reg;

    logic             grant;
    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;

    // Pick the port to serve: a lone requester wins outright, contention
    // goes to the port that was not served last.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (req_valid == 2'b11) begin
            grant = ~last_grant_reg;
        end
    end

    // Per-port handshake outputs; req_ready is forced low while reset is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi] = reset_n && (state_reg == IDLE) && req_valid[gi]
                                   && (grant == 1'(gi));
            assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign accept    = |req_ready;
    assign handshake = (state_reg == RESP) && rsp_ready[owner_reg];

    assign sel_a  = grant ? req_a1  : req_a0;
    assign sel_b  = grant ? req_b1  : req_b0;
    assign sel_op = grant ? req_op1 : req_op0;

    // Transaction sequencing: IDLE -> EXEC -> RESP -> IDLE on the owner's handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control state: FSM, round-robin pointer and the owner of the in-flight op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                last_grant_reg <= grant;
                owner_reg      <= grant;
            end
        end
    end

    // Datapath: ALU operands are latched on accept and held until the next
    // accept; the ALU output is sampled only at the end of EXEC, so no output
    // depends combinationally on alu_result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            srca_reg    <= '0;
            srcb_reg    <= '0;
            control_reg <= 3'b000;
            result_reg  <= '0;
        end else begin
            if (accept) begin
                srca_reg    <= sel_a;
                srcb_reg    <= sel_b;
                control_reg <= sel_op;
            end
            if (state_reg == EXEC) begin
                result_reg <= alu_result;
            end
        end
    end

    assign alu_srca    = srca_reg;
    assign alu_srcb    = srcb_reg;
    assign alu_control = control_reg;
    assign rsp_result  = result_reg;
    assign busy        = (state_reg != IDLE);

endmodule
